aca_ii_n16_q4_recovery: RTL and testbench

ACA_II_N16_Q4_RECOVERY -- requirements
Module: aca_ii_n16_q4_recovery

---
 rtl/aca_ii_n16_q4_recovery_pkg.sv | 28 ++
 rtl/aca_ii_n16_q4_recovery_window_flags.sv | 43 ++++
 rtl/aca_ii_n16_q4_recovery.sv | 129 ++++++++++++
 tb/tb_aca_ii_n16_q4_recovery.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/aca_ii_n16_q4_recovery_pkg.sv
// Shared constants and types for the N=16, Q=4 ACA-II adder with error recovery.
// Holds the window geometry, the controller state encoding and the result type.
package aca_ii_n16_q4_recovery_pkg;

  localparam int ACA_N     = 16;
  localparam int ACA_Q     = 4;
  localparam int NUM_WIN   = 7;
  localparam int NUM_FLAGS = NUM_WIN - 1;

  typedef logic [ACA_N:0] res_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_CORR,
    ST_DONE
  } state_e;

  function automatic logic [2:0] count_flags(input logic [NUM_FLAGS-1:0] flags);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      cnt = cnt + {2'b00, flags[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/aca_ii_n16_q4_recovery_window_flags.sv
// Combinational ACA-II core: approximate sum from overlapping 4-bit windows
// plus one flag per window (1..6) whose truncated carry chain lost a carry.
module aca_ii_window_flags
  import aca_ii_n16_q4_recovery_pkg::*;
(
  input  logic [ACA_N-1:0]     a_i,
  input  logic [ACA_N-1:0]     b_i,
  output res_t                 approx_o,
  output logic [NUM_FLAGS-1:0] flags_o
);

  // Per 2-bit group: generate with zero carry-in, and full propagate.
  logic [NUM_WIN-1:0] grp_g;
  logic [NUM_WIN-1:1] grp_p;
  logic [NUM_WIN-1:1] carry;

  // A window's upper field sees only the carry generated inside its own low
  // pair, which is exactly what a zero-carry-in 4-bit window sum produces.
  assign approx_o[3:0] = a_i[3:0] + b_i[3:0];
  assign approx_o[ACA_N:ACA_N-2] = {1'b0, a_i[ACA_N-1:ACA_N-2]}
                                 + {1'b0, b_i[ACA_N-1:ACA_N-2]}
                                 + {2'b00, grp_g[NUM_WIN-1]};

  for (genvar k = 0; k < NUM_WIN; k++) begin : g_grp
    assign grp_g[k] = (a_i[2*k+1] & b_i[2*k+1])
                    | ((a_i[2*k+1] ^ b_i[2*k+1]) & a_i[2*k] & b_i[2*k]);
  end

  for (genvar k = 1; k < NUM_WIN; k++) begin : g_win
    assign grp_p[k] = &(a_i[2*k+1:2*k] ^ b_i[2*k+1:2*k]);
    if (k == 1) begin : g_first
      assign carry[k] = grp_g[0];
    end else begin : g_chain
      assign carry[k] = grp_g[k-1] | (grp_p[k-1] & carry[k-1]);
    end
    assign flags_o[k-1] = carry[k] & grp_p[k];
    if (k < NUM_WIN - 1) begin : g_field
      assign approx_o[2*k+3:2*k+2] = a_i[2*k+3:2*k+2] + b_i[2*k+3:2*k+2]
                                   + {1'b0, grp_g[k]};
    end
  end

endmodule

// File: rtl/aca_ii_n16_q4_recovery.sv
// ACA-II approximate adder with sequential error recovery: one correction per
// cycle on the lowest flagged window until the exact sum is reached.
module aca_ii_n16_q4_recovery
  import aca_ii_n16_q4_recovery_pkg::*;
#(
  parameter int N = ACA_N,
  parameter int Q = ACA_Q
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in1_i,
  input  logic [N-1:0] in2_i,
  input  logic         approx_only_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N:0]   res_o,
  output logic [N:0]   approx_o,
  output logic         err_o,
  output logic [2:0]   err_cnt_o
);

  localparam int HALF = Q / 2;

  state_e               state_q, state_d;
  logic [N-1:0]         a_q, a_d, b_q, b_d;
  logic                 ao_q, ao_d;
  res_t                 res_q, res_d, approx_q, approx_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d, low_flag;
  logic [2:0]           err_cnt_q, err_cnt_d;

  res_t                 win_approx;
  logic [NUM_FLAGS-1:0] win_flags;

  aca_ii_window_flags u_window_flags (
    .a_i      (a_q),
    .b_i      (b_q),
    .approx_o (win_approx),
    .flags_o  (win_flags)
  );

  // Isolate the lowest pending flag (two's-complement trick).
  assign low_flag = flags_q & (~flags_q + NUM_FLAGS'(1));

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ao_d      = ao_q;
    res_d     = res_q;
    approx_d  = approx_q;
    flags_d   = flags_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          a_d     = in1_i;
          b_d     = in2_i;
          ao_d    = approx_only_i;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        res_d     = win_approx;
        approx_d  = win_approx;
        flags_d   = win_flags;
        err_cnt_d = count_flags(win_flags);
        state_d   = (win_flags == '0 || ao_q) ? ST_DONE : ST_CORR;
      end
      ST_CORR: begin
        // Fields are disjoint, so applying the single one-hot bit is enough.
        for (int k = 1; k < NUM_WIN; k++) begin
          if (low_flag[k-1]) begin
            if (k == NUM_WIN - 1) begin
              res_d[HALF*k+HALF +: 3] = res_q[HALF*k+HALF +: 3] + 3'd1;
            end else begin
              res_d[HALF*k+HALF +: 2] = res_q[HALF*k+HALF +: 2] + 2'd1;
            end
          end
        end
        flags_d = flags_q & ~low_flag;
        if (flags_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: all state, including the operand and result registers, is cleared
    // so the outputs read zero straight after reset.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      ao_q      <= 1'b0;
      res_q     <= '0;
      approx_q  <= '0;
      flags_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ao_q      <= ao_d;
      res_q     <= res_d;
      approx_q  <= approx_d;
      flags_q   <= flags_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign res_o       = res_q;
  assign approx_o    = approx_q;
  assign err_o       = (err_cnt_q != '0);
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_aca_ii_n16_q4_recovery.sv
// Scoreboard bench: the driver pushes expected results from an arithmetic
// reference model; an independent monitor checks every presented result.
module tb_aca_ii_n16_q4_recovery;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i, approx_only_i, out_ready_i;
  logic [15:0] in1_i, in2_i;
  logic        in_ready_o, out_valid_o, err_o;
  logic [16:0] res_o, approx_o;
  logic [2:0]  err_cnt_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [16:0] res;
    logic [16:0] approx;
    logic        err;
    logic [2:0]  cnt;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  aca_ii_n16_q4_recovery dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in1_i         (in1_i),
    .in2_i         (in2_i),
    .approx_only_i (approx_only_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .res_o         (res_o),
    .approx_o      (approx_o),
    .err_o         (err_o),
    .err_cnt_o     (err_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: windows summed independently, lost carries found from the exact
  // prefix sums; the corrected result is the plain arithmetic sum.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ao);
    exp_t        e;
    int unsigned ai, bi, w, apx, cnt, mask, cin, exact;
    ai  = a;
    bi  = b;
    apx = 0;
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      w = ((ai >> (2*k)) & 15) + ((bi >> (2*k)) & 15);
      if (k == 0)      apx = apx | (w & 15);
      else if (k < 6)  apx = apx | (((w >> 2) & 3) << (2*k+2));
      else             apx = apx | (((w >> 2) & 7) << 14);
    end
    for (int k = 1; k < 7; k++) begin
      mask = (1 << (2*k)) - 1;
      cin  = (((ai & mask) + (bi & mask)) >> (2*k)) & 1;
      if (cin == 1 && (((ai ^ bi) >> (2*k)) & 3) == 3) cnt++;
    end
    exact    = ai + bi;
    e.approx = apx[16:0];
    e.res    = ao ? apx[16:0] : exact[16:0];
    e.err    = (apx != exact);
    e.cnt    = cnt[2:0];
    e.lat    = 2 + (ao ? 0 : int'(cnt));
    e.acc    = 0;
    return e;
  endfunction

  // Monitor: latency is the count of rising edges from the accepting edge up
  // to and including the edge on which out_valid_o rises.
  exp_t cur;
  bit   active = 1'b0;
  always @(negedge clk) begin
    if (out_valid_o) begin
      if (!active) begin
        active = 1'b1;
        if (sb_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          cur = sb_q.pop_front();
          check("latency", cyc - cur.acc + 1, cur.lat);
        end
      end
      check("res_o", {15'd0, res_o}, {15'd0, cur.res});
      check("approx_o", {15'd0, approx_o}, {15'd0, cur.approx});
      check("err_o", {31'd0, err_o}, {31'd0, cur.err});
      check("err_cnt_o", {29'd0, err_cnt_o}, {29'd0, cur.cnt});
      check("in_ready_busy", {31'd0, in_ready_o}, 32'd0);
    end else begin
      active = 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ao,
                       input exp_t e, input int hold);
    int n;
    wait_ready();
    in1_i = a; in2_i = b; approx_only_i = ao; in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid_i = 1'b0; in1_i = 16'($urandom); in2_i = 16'($urandom);
    approx_only_i = 1'($urandom);
    n = 0;
    while (!out_valid_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_o) begin
      check("result_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      out_ready_i = 1'b0;
      in_valid_i  = 1'($urandom);
      in1_i       = 16'($urandom);
      @(negedge clk);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready_o}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid_o}, 32'd0);
    check({tag, "_res"}, {15'd0, res_o}, 32'd0);
    check({tag, "_approx"}, {15'd0, approx_o}, 32'd0);
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    check({tag, "_err_cnt"}, {29'd0, err_cnt_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [15:0] a, b;
    logic        ao;
    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; approx_only_i = 1'b0;
    in1_i = '0; in2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    e = '{res: 17'h00010, approx: 17'h00000, err: 1'b1, cnt: 3'd1, lat: 3, acc: 0};
    issue(16'h0006, 16'h000A, 1'b0, e, 1);
    e = '{res: 17'h10000, approx: 17'h0FFF0, err: 1'b1, cnt: 3'd6, lat: 8, acc: 0};
    issue(16'hFFFF, 16'h0001, 1'b0, e, 0);
    e = '{res: 17'h1FFFE, approx: 17'h1FFFE, err: 1'b0, cnt: 3'd0, lat: 2, acc: 0};
    issue(16'hFFFF, 16'hFFFF, 1'b0, e, 2);
    e = '{res: 17'h0FFF0, approx: 17'h0FFF0, err: 1'b1, cnt: 3'd6, lat: 2, acc: 0};
    issue(16'hFFFF, 16'h0001, 1'b1, e, 0);
    // Held result with stray in_valid_i pulses while waiting.
    e = '{res: 17'h00010, approx: 17'h00000, err: 1'b1, cnt: 3'd1, lat: 3, acc: 0};
    issue(16'h0006, 16'h000A, 1'b0, e, 5);

    // Reset in the middle of a long correction discards the operation.
    wait_ready();
    in1_i = 16'hFFFF; in2_i = 16'h0001; approx_only_i = 1'b0; in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_corr_reset");
    @(negedge clk);
    rst_n = 1'b1;
    e = '{res: 17'h00010, approx: 17'h00000, err: 1'b1, cnt: 3'd1, lat: 3, acc: 0};
    issue(16'h0006, 16'h000A, 1'b0, e, 0);

    for (int i = 0; i < 150; i++) begin
      case ($urandom % 4)
        0: begin a = 16'($urandom); b = ~a ^ 16'($urandom % 8); end
        1: begin a = 16'hFFFF; b = 16'($urandom % 64); end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      ao = ($urandom % 4 == 0);
      issue(a, b, ao, model(a, b, ao), int'($urandom % 4));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
